ad9648_spi_responder: RTL

- Synthesizable 3-wire SPI slave that models the AD9648 serial-port register map; it is the far end of the controller's SPI master (cs/sck/sdio).
- Used in loopback builds and benches to close the configuration path without silicon.
- Oversamples cs/sck/sdio in the system clock domain, decodes the 24-bit instruction+data frame, and serves writes and reads.
- Holds a shadow/active register bank with an AD9648-style transfer register (0xFF) and a self-clearing soft reset.

---
 rtl/ad9648_spi_pkg.sv | 29 ++
 rtl/ad9648_spi_responder_sync.sv | 41 ++++
 rtl/ad9648_spi_responder.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/ad9648_spi_pkg.sv
// Shared frame layout, special addresses and FSM encoding for the AD9648 SPI responder.
package ad9648_spi_pkg;

    localparam int RnwBit    = 23;
    localparam int WMsb      = 22;
    localparam int WLsb      = 21;
    localparam int AddrMsb   = 20;
    localparam int AddrLsb   = 8;
    localparam int InstrBits = 16;
    localparam int FrameBits = 24;

    localparam logic [12:0] AddrCfg    = 13'h000;
    localparam logic [12:0] AddrChipId = 13'h001;
    localparam logic [12:0] AddrXfer   = 13'h0FF;

    localparam int SoftRstBit = 5;
    localparam int XferBit    = 0;

    localparam logic [7:0] CfgDefault = 8'h18;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INSTR,
        ST_WDATA,
        ST_RDATA,
        ST_DONE
    } spi_state_e;

endpackage

// File: rtl/ad9648_spi_responder_sync.sv
// Two-flop synchronizers for cs/sck/sdio plus a third flop on cs/sck for edge pulses.
module spi_in_sync (
    input  logic clk_sys_i,
    input  logic rst_sys_clk_i,
    input  logic cs_i,
    input  logic sck_i,
    input  logic sdio_i,
    output logic cs_o,
    output logic sdio_o,
    output logic cs_fall_o,
    output logic cs_rise_o,
    output logic sck_rise_o,
    output logic sck_fall_o
);

    logic [2:0] cs_q;
    logic [2:0] sck_q;
    logic [1:0] sdio_q;

    // Shift chains. cs resets to "low" so a reset taken mid-frame (cs still low)
    // cannot fabricate a cs_fall; the responder waits for a genuine new frame.
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_clk_i) begin
            cs_q   <= '0;
            sck_q  <= '0;
            sdio_q <= '0;
        end else begin
            cs_q   <= {cs_q[1:0], cs_i};
            sck_q  <= {sck_q[1:0], sck_i};
            sdio_q <= {sdio_q[0], sdio_i};
        end
    end

    assign cs_o       = cs_q[1];
    assign sdio_o     = sdio_q[1];
    assign cs_fall_o  = cs_q[2] & ~cs_q[1];
    assign cs_rise_o  = ~cs_q[2] & cs_q[1];
    assign sck_rise_o = ~sck_q[2] & sck_q[1];
    assign sck_fall_o = sck_q[2] & ~sck_q[1];

endmodule

// File: rtl/ad9648_spi_responder.sv
// 3-wire SPI slave modelling the AD9648 register map (shadow/active banks, 0xFF transfer).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for cs_fall
// ST_INSTR | shifting in the 16-bit instruction
// ST_WDATA | shifting in 8 write-data bits, commit on the 24th rise
// ST_RDATA | driving 8 read-data bits on sck falls
// ST_DONE  | frame complete, ignore sck until cs_rise
module ad9648_spi_responder
    import ad9648_spi_pkg::*;
#(
    parameter int         NumRegs = 32,
    parameter logic [7:0] ChipId  = 8'h88,
    parameter bit         Cpol    = 1'b0,
    parameter bit         Cpha    = 1'b0
) (
    input  logic                 clk_sys_i,
    input  logic                 rst_sys_clk_i,
    input  logic                 cs_i,
    input  logic                 sck_i,
    input  logic                 sdio_i,
    output logic                 sdio_o,
    output logic                 sdio_t_o,
    output logic                 reg_wr_o,
    output logic [12:0]          reg_addr_o,
    output logic [7:0]           reg_wdata_o,
    output logic                 xfer_o,
    output logic [NumRegs*8-1:0] active_regs_o,
    output logic                 busy_o,
    output logic                 prot_err_o
);

    localparam int         DataBits     = FrameBits - InstrBits;
    localparam logic [4:0] LastInstrCnt = 5'(InstrBits - 1);
    localparam logic [4:0] LastFrameCnt = 5'(FrameBits - 1);

    if (NumRegs < 2 || NumRegs > 256) begin : g_bad_numregs
        $error("NumRegs must be in 2..256");
    end
    if (Cpol != 1'b0 || Cpha != 1'b0) begin : g_bad_mode
        $error("only SPI mode 0 is supported");
    end

    logic cs_s, sdio_s, cs_fall, cs_rise, sck_rise, sck_fall;

    spi_in_sync u_sync (
        .clk_sys_i    (clk_sys_i),
        .rst_sys_clk_i(rst_sys_clk_i),
        .cs_i         (cs_i),
        .sck_i        (sck_i),
        .sdio_i       (sdio_i),
        .cs_o         (cs_s),
        .sdio_o       (sdio_s),
        .cs_fall_o    (cs_fall),
        .cs_rise_o    (cs_rise),
        .sck_rise_o   (sck_rise),
        .sck_fall_o   (sck_fall)
    );

    spi_state_e           state_q, state_d;
    logic [4:0]           bit_cnt_q, bit_cnt_d;
    logic [FrameBits-2:0] frame_q, frame_d;
    logic [FrameBits-1:0] frame_in;
    logic [7:0]           rd_q, rd_d, rd_lookup;
    logic                 drive_q, drive_d;
    logic                 wr_q, wr_d, xfer_q, xfer_d, prot_q, prot_d;
    logic [12:0]          addr_q, addr_d, dec_addr, cmt_addr;
    logic [7:0]           wdata_q, wdata_d, cmt_data;
    logic [7:0]           shadow_q [NumRegs];
    logic [7:0]           shadow_d [NumRegs];
    logic [7:0]           active_q [NumRegs];
    logic [7:0]           active_d [NumRegs];
    logic [7:0]           defaults [NumRegs];

    // Instruction fields sit 8 bits lower while only 16 bits have arrived.
    assign frame_in = {frame_q, sdio_s};
    assign dec_addr = frame_in[AddrMsb-DataBits:AddrLsb-DataBits];
    assign cmt_addr = frame_in[AddrMsb:AddrLsb];
    assign cmt_data = frame_in[7:0];

    // Power-on / soft-reset register values.
    always_comb begin
        for (int i = 0; i < NumRegs; i++) defaults[i] = 8'h00;
        defaults[int'(AddrCfg)]    = CfgDefault;
        defaults[int'(AddrChipId)] = ChipId;
    end

    // Read value for the address being decoded; 0xFF and holes read as zero.
    always_comb begin
        rd_lookup = 8'h00;
        if (dec_addr == AddrChipId) begin
            rd_lookup = ChipId;
        end else if (dec_addr != AddrXfer) begin
            for (int i = 0; i < NumRegs; i++) begin
                if (dec_addr == 13'(i)) rd_lookup = shadow_q[i];
            end
        end
    end

    // Frame FSM, write commit and read shifter.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        rd_d      = rd_q;
        drive_d   = drive_q;
        wr_d      = 1'b0;
        xfer_d    = 1'b0;
        prot_d    = prot_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        shadow_d  = shadow_q;
        active_d  = active_q;

        if (cs_rise) begin
            state_d = ST_IDLE;
            drive_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_d   = ST_INSTR;
                        bit_cnt_d = 5'd0;
                    end
                end
                ST_INSTR: begin
                    if (sck_rise) begin
                        frame_d   = frame_in[FrameBits-2:0];
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == LastInstrCnt) begin
                            addr_d = dec_addr;
                            if (frame_in[WMsb-DataBits:WLsb-DataBits] != 2'b00) prot_d = 1'b1;
                            if (frame_in[RnwBit-DataBits]) begin
                                state_d = ST_RDATA;
                                rd_d    = rd_lookup;
                            end else begin
                                state_d = ST_WDATA;
                            end
                        end
                    end
                end
                ST_WDATA: begin
                    if (sck_rise) begin
                        frame_d   = frame_in[FrameBits-2:0];
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == LastFrameCnt && !frame_in[RnwBit]) begin
                            state_d = ST_DONE;
                            wr_d    = 1'b1;
                            addr_d  = cmt_addr;
                            wdata_d = cmt_data;
                            if (cmt_addr == AddrXfer) begin
                                if (cmt_data[XferBit]) begin
                                    active_d = shadow_q;
                                    xfer_d   = 1'b1;
                                end
                            end else if (cmt_addr == AddrCfg && cmt_data[SoftRstBit]) begin
                                shadow_d = defaults;
                                active_d = defaults;
                            end else if (cmt_addr != AddrChipId) begin
                                for (int i = 0; i < NumRegs; i++) begin
                                    if (cmt_addr == 13'(i)) shadow_d[i] = cmt_data;
                                end
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    if (sck_fall) begin
                        if (!drive_q) drive_d = 1'b1;
                        else          rd_d    = {rd_q[6:0], 1'b0};
                    end
                    if (sck_rise) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == LastFrameCnt) state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (sck_fall) drive_d = 1'b0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and bank registers.
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_clk_i) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            frame_q   <= '0;
            rd_q      <= '0;
            drive_q   <= 1'b0;
            wr_q      <= 1'b0;
            xfer_q    <= 1'b0;
            prot_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            shadow_q  <= defaults;
            active_q  <= defaults;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            frame_q   <= frame_d;
            rd_q      <= rd_d;
            drive_q   <= drive_d;
            wr_q      <= wr_d;
            xfer_q    <= xfer_d;
            prot_q    <= prot_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
        end
    end

    // Flatten the active bank.
    always_comb begin
        active_regs_o = '0;
        for (int i = 0; i < NumRegs; i++) active_regs_o[8*i +: 8] = active_q[i];
    end

    assign sdio_o      = rd_q[7];
    assign sdio_t_o    = ~drive_q;
    assign reg_wr_o    = wr_q;
    assign reg_addr_o  = addr_q;
    assign reg_wdata_o = wdata_q;
    assign xfer_o      = xfer_q;
    assign busy_o      = (state_q != ST_IDLE) & ~cs_s;
    assign prot_err_o  = prot_q;

endmodule
